// File: rtl/wb_master_if_if.sv
// Signal bundle between the SPI command side, the Wishbone master and the
// Wishbone slave. The master modport is the bridge's view; the slave
// modport is the view of whatever surrounds it (command decoder + bus slave).
//
// Handshake rules:
//   Request: REQ_VALID/REQ_READY. A request transfers on a rising edge where
//   both are high; REQ_READY is high only while the master is idle.
//   Response: RSP_VALID is a single-cycle pulse with no backpressure. The
//   consumer must take RSP_DATA/RSP_ERR in that cycle.
//   Bus: classic Wishbone. CYC and STB are identical. ACK is only honoured
//   while a cycle is open.
interface wb_master_if_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic        REQ_WE;
  logic [7:0]  REQ_ADDR;
  logic [31:0] REQ_DATA;
  logic        RSP_VALID;
  logic [31:0] RSP_DATA;
  logic        RSP_ERR;
  logic [7:0]  ERR_CNT;
  logic [7:0]  WB_ADR_O;
  logic [31:0] WB_DAT_O;
  logic [31:0] WB_DAT_I;
  logic        WB_WE_O;
  logic        WB_CYC_O;
  logic        WB_STB_O;
  logic        WB_ACK_I;

  modport master (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_DATA, WB_DAT_I, WB_ACK_I,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, ERR_CNT,
           WB_ADR_O, WB_DAT_O, WB_WE_O, WB_CYC_O, WB_STB_O
  );

  modport slave (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_DATA, WB_DAT_I, WB_ACK_I,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR, ERR_CNT,
           WB_ADR_O, WB_DAT_O, WB_WE_O, WB_CYC_O, WB_STB_O
  );
endinterface

// File: rtl/wb_master_if.sv
// Wishbone classic single-transfer master for the SPI-to-Wishbone bridge.
// Takes one local request at a time and runs one bus cycle for it. It then
// returns a one-cycle response. An ACK timeout aborts cycles to dead slaves,
// and a saturating counter tallies those aborts.
module wb_master_if #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              WB_CLK_I,
  input  logic              WB_RST_I,
  wb_master_if_if.master    bus,
  output logic [1:0]        o_dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter value on the last bus-phase edge before the cycle is aborted.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_adr;
  logic [31:0] r_dat;
  logic        r_we;
  logic        r_cyc;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;
  logic [7:0]  r_err_cnt;
  logic        w_req_ready;

  // Ready only in IDLE. It is held low while reset is asserted so that every
  // output reads zero during reset.
  assign w_req_ready = (r_state == IDLE) && !WB_RST_I;

  assign bus.REQ_READY = w_req_ready;
  assign bus.RSP_VALID = r_rsp_valid;
  assign bus.RSP_DATA  = r_rsp_data;
  assign bus.RSP_ERR   = r_rsp_err;
  assign bus.ERR_CNT   = r_err_cnt;
  assign bus.WB_ADR_O  = r_adr;
  assign bus.WB_DAT_O  = r_dat;
  assign bus.WB_WE_O   = r_we;
  assign bus.WB_CYC_O  = r_cyc;
  assign bus.WB_STB_O  = r_cyc;
  assign o_dbg_state   = r_state;

  // Transaction FSM: accept in IDLE, wait for ACK or timeout in BUS,
  // then spend one DONE cycle that ends the response pulse.
  always_ff @(posedge WB_CLK_I or posedge WB_RST_I) begin
    if (WB_RST_I) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_we        <= 1'b0;
      r_cyc       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.REQ_VALID) begin
            r_adr   <= bus.REQ_ADDR;
            r_dat   <= bus.REQ_DATA;
            r_we    <= bus.REQ_WE;
            r_cyc   <= 1'b1;
            r_cnt   <= '0;
            r_state <= BUS;
          end
        end
        BUS: begin
          // ACK is checked first, so a response on the expiry edge still counts.
          if (bus.WB_ACK_I) begin
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= r_we ? 32'd0 : bus.WB_DAT_I;
            r_state     <= DONE;
          end else if (r_cnt == LAST_CNT) begin
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= 32'd0;
            if (r_err_cnt != 8'hFF) begin
              r_err_cnt <= r_err_cnt + 8'd1;
            end
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_cyc       <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_if.sv
// Directed and randomized bench for wb_master_if. A transaction-level model
// predicts each response from the slave's ACK timing. It yields the response
// edge, the CYC length, the error flag, the returned data and the timeout tally.
module tb_wb_master_if;

  localparam int TO = 16;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  wb_master_if_if bus_if ();

  wb_master_if #(.TIMEOUT_CYCLES(TO)) dut (
    .WB_CLK_I    (clk),
    .WB_RST_I    (rst),
    .bus         (bus_if),
    .o_dbg_state (dbg_state)
  );

  int n_total = 0;
  int n_pass  = 0;
  int exp_err_cnt = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=time_limit expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Runs one transaction starting at a negedge with the master idle.
  // ack_at = the bus-phase edge at which the slave raises ACK.
  // A value of 0, or any value above TO, means the slave never answers.
  task automatic run_txn(input logic we, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int ack_at);
    logic        exp_err;
    int          eff;
    logic [31:0] exp_data;
    int          k;
    int          cyc_cnt;
    logic        held;
    logic        got;
    exp_err  = !(ack_at >= 1 && ack_at <= TO);
    eff      = exp_err ? TO : ack_at;
    exp_data = (exp_err || we) ? 32'd0 : rdata;
    if (exp_err && exp_err_cnt < 255) exp_err_cnt++;

    bus_if.REQ_VALID = 1'b1;
    bus_if.REQ_WE    = we;
    bus_if.REQ_ADDR  = addr;
    bus_if.REQ_DATA  = wdata;
    bus_if.WB_ACK_I  = 1'b0;
    bus_if.WB_DAT_I  = rdata;
    chk("ready_idle", 32'(bus_if.REQ_READY), 32'd1);
    @(posedge clk); @(negedge clk);
    bus_if.REQ_VALID = 1'b0;
    bus_if.REQ_ADDR  = 8'($urandom);
    bus_if.REQ_DATA  = $urandom;
    bus_if.REQ_WE    = ~we;
    chk("cyc_after_accept", 32'(bus_if.WB_CYC_O), 32'd1);
    chk("stb_after_accept", 32'(bus_if.WB_STB_O), 32'd1);
    chk("adr", 32'(bus_if.WB_ADR_O), 32'(addr));
    chk("dat", bus_if.WB_DAT_O, wdata);
    chk("we", 32'(bus_if.WB_WE_O), 32'(we));

    cyc_cnt = 0; held = 1'b1; got = 1'b0; k = 0;
    while (!got && k < TO + 3) begin
      if (bus_if.WB_CYC_O) cyc_cnt++;
      if (bus_if.WB_CYC_O && (bus_if.WB_ADR_O !== addr || bus_if.WB_DAT_O !== wdata ||
          bus_if.WB_WE_O !== we || bus_if.WB_STB_O !== 1'b1 || bus_if.REQ_READY !== 1'b0))
        held = 1'b0;
      k++;
      bus_if.WB_ACK_I = (k == ack_at);
      @(posedge clk); @(negedge clk);
      bus_if.WB_ACK_I = 1'b0;
      got = bus_if.RSP_VALID;
    end
    chk("rsp_seen", 32'(got), 32'd1);
    chk("rsp_edge", 32'(k), 32'(eff));
    chk("cyc_cycles", 32'(cyc_cnt), 32'(eff));
    chk("bus_held", 32'(held), 32'd1);
    chk("rsp_err", 32'(bus_if.RSP_ERR), 32'(exp_err));
    chk("rsp_data", bus_if.RSP_DATA, exp_data);
    chk("err_cnt", 32'(bus_if.ERR_CNT), 32'(exp_err_cnt));
    chk("cyc_low_at_rsp", 32'(bus_if.WB_CYC_O), 32'd0);
    chk("stb_low_at_rsp", 32'(bus_if.WB_STB_O), 32'd0);
    chk("ready_low_at_rsp", 32'(bus_if.REQ_READY), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("rsp_one_cycle", 32'(bus_if.RSP_VALID), 32'd0);
    chk("ready_after_done", 32'(bus_if.REQ_READY), 32'd1);
    chk("rsp_data_hold", bus_if.RSP_DATA, exp_data);
    chk("rsp_err_hold", 32'(bus_if.RSP_ERR), 32'(exp_err));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n_rsp;
    int n_bad;
    rst = 1'b1;
    bus_if.REQ_VALID = 1'b0;
    bus_if.REQ_WE    = 1'b0;
    bus_if.REQ_ADDR  = '0;
    bus_if.REQ_DATA  = '0;
    bus_if.WB_DAT_I  = '0;
    bus_if.WB_ACK_I  = 1'b0;
    #1;
    chk("rst_cyc", 32'(bus_if.WB_CYC_O), 32'd0);
    chk("rst_rsp_valid", 32'(bus_if.RSP_VALID), 32'd0);
    chk("rst_err_cnt", 32'(bus_if.ERR_CNT), 32'd0);
    chk("rst_ready", 32'(bus_if.REQ_READY), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 32'(bus_if.REQ_READY), 32'd1);
    @(negedge clk);

    // Write with a zero-wait slave.
    run_txn(1'b1, 8'h12, 32'hDEADBEEF, 32'h1234_5678, 1);
    // Read with three wait states.
    run_txn(1'b0, 8'h34, 32'h0, 32'hA5A5_0F0F, 4);
    // Dead slave.
    run_txn(1'b0, 8'h56, 32'h0, 32'hFFFF_FFFF, 0);
    // ACK exactly on the expiry edge.
    run_txn(1'b0, 8'h78, 32'h0, 32'hCAFE_F00D, TO);

    // Random mix of reads/writes, wait states and timeouts.
    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom, $urandom,
              int'($urandom_range(0, TO + 2)));
    end

    // Drive the timeout counter into saturation.
    for (int i = 0; i < 300; i++) begin
      run_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom, $urandom, 0);
    end
    chk("err_cnt_saturated", 32'(bus_if.ERR_CNT), 32'd255);

    // Continuous requests against a zero-wait slave: one per 3 cycles.
    bus_if.REQ_VALID = 1'b1;
    bus_if.REQ_WE    = 1'b1;
    n_rsp = 0; n_bad = 0;
    for (int i = 0; i < 30; i++) begin
      bus_if.WB_ACK_I = bus_if.WB_CYC_O;
      bus_if.REQ_DATA = $urandom;
      @(posedge clk); @(negedge clk);
      if (bus_if.RSP_VALID) begin
        n_rsp++;
        if (bus_if.RSP_ERR !== 1'b0 || bus_if.RSP_DATA !== 32'd0) n_bad++;
      end
    end
    bus_if.REQ_VALID = 1'b0;
    bus_if.WB_ACK_I  = 1'b0;
    chk("b2b_rsp_count", 32'(n_rsp), 32'd10);
    chk("b2b_rsp_ok", 32'(n_bad), 32'd0);
    @(negedge clk); @(negedge clk);

    // Stray ACKs while idle must do nothing.
    n_rsp = 0; n_bad = 0;
    for (int i = 0; i < 8; i++) begin
      bus_if.WB_ACK_I = 1'b1;
      @(posedge clk); @(negedge clk);
      if (bus_if.RSP_VALID) n_rsp++;
      if (bus_if.WB_CYC_O || !bus_if.REQ_READY) n_bad++;
    end
    bus_if.WB_ACK_I = 1'b0;
    chk("stray_ack_rsp", 32'(n_rsp), 32'd0);
    chk("stray_ack_idle", 32'(n_bad), 32'd0);
    chk("stray_ack_err_cnt", 32'(bus_if.ERR_CNT), 32'd255);

    // Reset in the middle of a bus cycle.
    bus_if.REQ_VALID = 1'b1;
    bus_if.REQ_WE    = 1'b1;
    bus_if.REQ_ADDR  = 8'h9C;
    bus_if.REQ_DATA  = 32'h0BAD_F00D;
    @(posedge clk); @(negedge clk);
    bus_if.REQ_VALID = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("pre_rst_cyc", 32'(bus_if.WB_CYC_O), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cyc", 32'(bus_if.WB_CYC_O), 32'd0);
    chk("mid_rst_stb", 32'(bus_if.WB_STB_O), 32'd0);
    chk("mid_rst_adr", 32'(bus_if.WB_ADR_O), 32'd0);
    chk("mid_rst_dat", bus_if.WB_DAT_O, 32'd0);
    chk("mid_rst_we", 32'(bus_if.WB_WE_O), 32'd0);
    chk("mid_rst_err_cnt", 32'(bus_if.ERR_CNT), 32'd0);
    chk("mid_rst_rsp", 32'(bus_if.RSP_VALID), 32'd0);
    chk("mid_rst_ready", 32'(bus_if.REQ_READY), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_err_cnt = 0;
    #1;
    chk("post_rst_ready", 32'(bus_if.REQ_READY), 32'd1);
    chk("post_rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    run_txn(1'b0, 8'hE1, 32'h0, 32'h5555_AAAA, 2);
    run_txn(1'b1, 8'hE2, 32'h7777_8888, 32'h0, 0);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_master_if.md
# wb_master_if

Wishbone classic single-cycle bus master for the SPI-to-Wishbone bridge. It takes one read or write request at a time from the local command side (the SPI command decoder), runs a single Wishbone bus cycle, and returns the read data or write completion as a one-cycle response. A bounded ACK timeout prevents a dead slave from hanging the bridge. A saturating counter records how many timeouts have occurred.

## Interface
- TIMEOUT_CYCLES, 16, number of clock cycles in the bus phase without WB_ACK_I before the cycle is aborted; legal range 2..255.
- WB_CLK_I  in  1  single clock; all logic on rising edge.
- WB_RST_I  in  1  reset, asynchronous, active-high.
- REQ_VALID  in  1  local request present.
- REQ_READY  out  1  block can accept a request; high only in IDLE.
- REQ_WE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  8  target address.
- REQ_DATA  in  32  write data; ignored for reads.
- RSP_VALID  out  1  one-cycle response pulse.
- RSP_DATA  out  32  read data; 0 for writes and errors.
- RSP_ERR  out  1  1 = timeout abort; qualified by RSP_VALID.
- ERR_CNT  out  8  saturating count of timeouts since reset.
- WB_ADR_O  out  8  Wishbone address.
- WB_DAT_O  out  32  Wishbone write data.
- WB_DAT_I  in  32  Wishbone read data.
- WB_WE_O  out  1  Wishbone write enable.
- WB_CYC_O  out  1  Wishbone cycle.
- WB_STB_O  out  1  Wishbone strobe; always equal to WB_CYC_O.
- WB_ACK_I  in  1  Wishbone acknowledge.

## Operation
- Reset (asynchronous, takes effect immediately, including mid-cycle):
  - state = IDLE; all outputs 0.
  - Internal timeout counter = 0; ERR_CNT = 0.
  - WB_CYC_O/WB_STB_O drop at once.
- FSM states: IDLE, BUS, DONE. REQ_READY = (state == IDLE), decoded from the state register.
- IDLE: on an edge with REQ_VALID = 1:
  - Register REQ_ADDR→WB_ADR_O, REQ_DATA→WB_DAT_O, REQ_WE→WB_WE_O.
  - Set WB_CYC_O = WB_STB_O = 1; clear the timeout counter; go to BUS.
  - With REQ_VALID = 0, outputs hold their values; CYC/STB stay 0.
- BUS: WB_ADR_O, WB_DAT_O and WB_WE_O are held stable. Each edge:
  - If WB_ACK_I = 1:
    - CYC/STB ← 0; RSP_VALID ← 1; RSP_ERR ← 0.
    - RSP_DATA ← WB_DAT_I for a read, 0 for a write.
    - Go to DONE.
  - Else if counter == TIMEOUT_CYCLES−1:
    - CYC/STB ← 0; RSP_VALID ← 1; RSP_ERR ← 1; RSP_DATA ← 0.
    - ERR_CNT ← ERR_CNT+1, saturating at 255.
    - Go to DONE.
  - Else counter ← counter+1.
  - ACK on the same edge as timeout expiry: ACK wins; no error is flagged and ERR_CNT is unchanged.
- DONE: RSP_VALID ← 0; go to IDLE. REQ_VALID is not accepted in DONE.
- WB_ACK_I outside BUS is ignored and has no state effect.
- RSP_DATA and RSP_ERR hold their values until the next response.
- The local side has no response backpressure; the consumer must take RSP_VALID in the cycle it is asserted.

## Timing
- Accept edge E0 → WB_CYC_O high after E0.
- ACK first sampled high at edge En (n ≥ 1):
  - RSP_VALID high for exactly one cycle, between En and En+1.
  - CYC/STB low after En.
  - REQ_READY high after En+1.
- Zero-wait slave (ACK at E1): request-to-response 2 edges; back-to-back transaction rate is 1 per 3 cycles.
- Timeout: CYC/STB is high for exactly TIMEOUT_CYCLES cycles; RSP_VALID with RSP_ERR = 1 after edge E(TIMEOUT_CYCLES).
- The block never asserts CYC for more than TIMEOUT_CYCLES cycles per transaction.

## Test plan
- Write, REQ_ADDR = 0x12, REQ_DATA = 0xDEADBEEF, slave ACKs on its 1st sampled cycle:
  - WB_ADR_O = 0x12, WB_DAT_O = 0xDEADBEEF, WE = 1 during the bus cycle.
  - RSP_VALID one cycle, RSP_ERR = 0, RSP_DATA = 0.
- Read, address 0x34, slave ACKs after 3 wait cycles with WB_DAT_I = 0xA5A5_0F0F:
  - CYC high for 4 cycles.
  - RSP_DATA = 0xA5A50F0F; REQ_READY low throughout, then high.
- No ACK, TIMEOUT_CYCLES = 16:
  - CYC high for exactly 16 cycles.
  - RSP_ERR = 1, RSP_DATA = 0, ERR_CNT 0→1.
  - Repeat 300 times → ERR_CNT = 255.
- ACK arrives on the expiry edge: RSP_ERR = 0, ERR_CNT unchanged, read data captured.
- REQ_VALID held high continuously with a zero-wait slave:
  - One request accepted per 3 cycles.
  - Stray WB_ACK_I pulses in IDLE cause no response.
- Assert WB_RST_I mid-BUS:
  - CYC/STB and all outputs drop to 0 without waiting for a clock edge.
  - After release, state is IDLE with REQ_READY = 1.
